// File: rtl/sequencer.sv
// Microcoded-style control sequencer for a single-accumulator CPU.
// The state register is the only storage; all control lines decode from it.
module sequencer #(
  parameter int OP_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  output logic            halted,
  output logic            PC_bus,
  output logic            Addr_bus,
  output logic            MDR_bus,
  output logic            ACC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_MAR,
  output logic            load_IR,
  output logic            load_MDR,
  output logic            load_ACC,
  output logic            CS,
  output logic            R_NW,
  output logic            ALU_ACC,
  output logic [1:0]      ALU_op
);

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  typedef enum logic [3:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_DEC,
    S_ST0,
    S_ST1,
    S_RD,
    S_LDA,
    S_ALU,
    S_BR,
    S_HALT
  } state_t;

  state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: state <= run ? S_F0 : S_IDLE;
        S_F0:   state <= S_F1;
        S_F1:   state <= S_F2;
        S_F2:   state <= S_DEC;
        S_DEC: begin
          case (op)
            OP_LOAD,
            OP_ADD,
            OP_SUB,
            OP_XOR:   state <= S_RD;
            OP_STORE: state <= S_ST0;
            OP_JMP:   state <= S_BR;
            OP_BNE:   state <= z_flag ? S_F0 : S_BR;
            OP_HALT:  state <= S_HALT;
            default:  state <= S_F0;
          endcase
        end
        S_ST0:  state <= S_ST1;
        S_ST1:  state <= S_F0;
        S_RD:   state <= (op == OP_LOAD) ? S_LDA : S_ALU;
        S_LDA:  state <= S_F0;
        S_ALU:  state <= S_F0;
        S_BR:   state <= S_F0;
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic mem_op;
  assign mem_op = (op == OP_LOAD) || (op == OP_ADD) ||
                  (op == OP_SUB)  || (op == OP_XOR) ||
                  (op == OP_STORE);

  always_comb begin
    halted   = 1'b0;
    PC_bus   = 1'b0;
    Addr_bus = 1'b0;
    MDR_bus  = 1'b0;
    ACC_bus  = 1'b0;
    load_PC  = 1'b0;
    INC_PC   = 1'b0;
    load_MAR = 1'b0;
    load_IR  = 1'b0;
    load_MDR = 1'b0;
    load_ACC = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b0;
    ALU_ACC  = 1'b0;
    ALU_op   = 2'b00;
    unique case (state)
      S_IDLE: ;
      S_F0: begin
        PC_bus   = 1'b1;
        load_MAR = 1'b1;
        INC_PC   = 1'b1;
        load_PC  = 1'b1;
      end
      S_F1: begin
        CS   = 1'b1;
        R_NW = 1'b1;
      end
      S_F2: begin
        MDR_bus = 1'b1;
        load_IR = 1'b1;
      end
      S_DEC: begin
        Addr_bus = mem_op;
        load_MAR = mem_op;
      end
      S_ST0: begin
        ACC_bus  = 1'b1;
        load_MDR = 1'b1;
      end
      S_ST1: CS = 1'b1;
      S_RD: begin
        CS   = 1'b1;
        R_NW = 1'b1;
      end
      S_LDA: begin
        MDR_bus  = 1'b1;
        load_ACC = 1'b1;
      end
      S_ALU: begin
        MDR_bus  = 1'b1;
        load_ACC = 1'b1;
        ALU_ACC  = 1'b1;
        if (op == OP_SUB)
          ALU_op = 2'b01;
        else if (op == OP_XOR)
          ALU_op = 2'b10;
      end
      S_BR: begin
        Addr_bus = 1'b1;
        load_PC  = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sequencer.sv
// Directed-vector bench for sequencer: expected control words go into a
// queue per cycle and a negedge monitor pops and compares them.
module tb_sequencer;

  logic       clock;
  logic       reset;
  logic       run;
  logic [2:0] op;
  logic       z_flag;
  logic       halted, PC_bus, Addr_bus, MDR_bus, ACC_bus;
  logic       load_PC, INC_PC, load_MAR, load_IR, load_MDR, load_ACC;
  logic       CS, R_NW, ALU_ACC;
  logic [1:0] ALU_op;

  sequencer #(.OP_W(3)) dut (
    .clock(clock), .reset(reset), .run(run), .op(op), .z_flag(z_flag),
    .halted(halted), .PC_bus(PC_bus), .Addr_bus(Addr_bus),
    .MDR_bus(MDR_bus), .ACC_bus(ACC_bus), .load_PC(load_PC),
    .INC_PC(INC_PC), .load_MAR(load_MAR), .load_IR(load_IR),
    .load_MDR(load_MDR), .load_ACC(load_ACC), .CS(CS), .R_NW(R_NW),
    .ALU_ACC(ALU_ACC), .ALU_op(ALU_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {halted,PC,Addr,MDR,ACC buses,ldPC,incPC,ldMAR,ldIR,ldMDR,ldACC,CS,RNW,ALUACC,ALUop}
  localparam logic [15:0] E_IDLE = 16'h0000;
  localparam logic [15:0] E_F0   = 16'h4700;
  localparam logic [15:0] E_F1   = 16'h0018;
  localparam logic [15:0] E_F2   = 16'h1080;
  localparam logic [15:0] E_DM   = 16'h2100;
  localparam logic [15:0] E_D0   = 16'h0000;
  localparam logic [15:0] E_ST0  = 16'h0840;
  localparam logic [15:0] E_ST1  = 16'h0010;
  localparam logic [15:0] E_RD   = 16'h0018;
  localparam logic [15:0] E_LDA  = 16'h1020;
  localparam logic [15:0] E_ADD  = 16'h1024;
  localparam logic [15:0] E_SUB  = 16'h1025;
  localparam logic [15:0] E_XOR  = 16'h1026;
  localparam logic [15:0] E_BR   = 16'h2400;
  localparam logic [15:0] E_HLT  = 16'h8000;

  logic [15:0] act;
  assign act = {halted, PC_bus, Addr_bus, MDR_bus, ACC_bus, load_PC,
                INC_PC, load_MAR, load_IR, load_MDR, load_ACC, CS, R_NW,
                ALU_ACC, ALU_op};

  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          started = 1'b0;

  // Inputs for a cycle go on just after the edge; the expected word is
  // what the outputs must show for the rest of that cycle.
  task automatic cyc(input logic r, input logic rn, input logic [2:0] o,
                     input logic z, input logic [15:0] e, input string t);
    @(posedge clock);
    #1;
    reset  = r;
    run    = rn;
    op     = o;
    z_flag = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic fetch(input logic [2:0] o, input logic z);
    cyc(0, 1, o, z, E_F0, "F0");
    cyc(0, 1, o, z, E_F1, "F1");
    cyc(0, 1, o, z, E_F2, "F2");
  endtask

  always @(negedge clock) begin
    logic [15:0] e;
    string       t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h at %0t", t, act, e, $time);
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      n_cmp++;
      assert ($onehot0({PC_bus, Addr_bus, MDR_bus, ACC_bus})) else begin
        n_bad++;
        $display("FAIL bus_onehot: got %b expected at most one set",
                 {PC_bus, Addr_bus, MDR_bus, ACC_bus});
      end
    end
  end

  initial begin
    reset  = 1'b1;
    run    = 1'b0;
    op     = 3'd0;
    z_flag = 1'b0;
    cyc(1, 0, 3'd0, 0, E_IDLE, "reset0");
    started = 1'b1;
    cyc(1, 0, 3'd0, 0, E_IDLE, "reset1");
    cyc(0, 1, 3'd0, 0, E_IDLE, "idle_run");
    // LOAD
    fetch(3'd0, 0);
    cyc(0, 1, 3'd0, 0, E_DM,  "ld_dec");
    cyc(0, 1, 3'd0, 0, E_RD,  "ld_rd");
    cyc(0, 1, 3'd0, 0, E_LDA, "ld_lda");
    // STORE, with run dropping mid-instruction
    fetch(3'd1, 0);
    cyc(0, 1, 3'd1, 0, E_DM,  "st_dec");
    cyc(0, 0, 3'd1, 0, E_ST0, "st_st0");
    cyc(0, 0, 3'd1, 0, E_ST1, "st_st1");
    // ADD / SUB / XOR
    fetch(3'd2, 0);
    cyc(0, 1, 3'd2, 0, E_DM,  "add_dec");
    cyc(0, 1, 3'd2, 0, E_RD,  "add_rd");
    cyc(0, 1, 3'd2, 0, E_ADD, "add_alu");
    fetch(3'd3, 0);
    cyc(0, 1, 3'd3, 0, E_DM,  "sub_dec");
    cyc(0, 1, 3'd3, 0, E_RD,  "sub_rd");
    cyc(0, 1, 3'd3, 0, E_SUB, "sub_alu");
    fetch(3'd4, 0);
    cyc(0, 1, 3'd4, 0, E_DM,  "xor_dec");
    cyc(0, 1, 3'd4, 0, E_RD,  "xor_rd");
    cyc(0, 1, 3'd4, 0, E_XOR, "xor_alu");
    // BNE taken, BNE not taken, JMP
    fetch(3'd5, 0);
    cyc(0, 1, 3'd5, 0, E_D0,  "bne_t_dec");
    cyc(0, 1, 3'd5, 0, E_BR,  "bne_t_br");
    fetch(3'd5, 1);
    cyc(0, 1, 3'd5, 1, E_D0,  "bne_n_dec");
    fetch(3'd6, 0);
    cyc(0, 1, 3'd6, 0, E_D0,  "jmp_dec");
    cyc(0, 1, 3'd6, 0, E_BR,  "jmp_br");
    // reset in ST0 must not reach ST1
    fetch(3'd1, 0);
    cyc(0, 1, 3'd1, 0, E_DM,  "rst_dec");
    cyc(1, 0, 3'd1, 0, E_ST0, "rst_st0");
    cyc(0, 0, 3'd1, 0, E_IDLE, "rst_idle");
    cyc(0, 0, 3'd1, 0, E_IDLE, "idle_hold");
    cyc(0, 1, 3'd7, 0, E_IDLE, "idle_go");
    // HALT holds despite run, exits only via reset
    fetch(3'd7, 0);
    cyc(0, 1, 3'd7, 0, E_D0,  "hlt_dec");
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 3'd7, 0, E_HLT, "halt_hold");
    cyc(1, 1, 3'd7, 0, E_HLT, "halt_rst");
    cyc(0, 0, 3'd0, 0, E_IDLE, "post_rst");
    cyc(0, 0, 3'd0, 0, E_IDLE, "post_idle");
    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
